sample_ramp_interpolator: RTL

Consumer end of the LIA low-pass sample stream. It accepts sparse, valid-qualified signed samples from the cascaded averaging filters and produces a continuous, every-clock output. Each new sample is approached by a linear ramp over a fixed 2^ramp_shift cycles, or reached in one cycle in hold mode. Sits between the LIA filter output and the lock-loop error/DAC path, which needs a glitch-free per-clock value.

---
 rtl/opo_package.sv | 10 +
 rtl/sample_ramp_interpolator_if.sv | 27 ++
 rtl/sample_ramp_interpolator.sv | 97 +++++++++
 3 files changed

// File: rtl/opo_package.sv
`default_nettype none
// ============================================================================
//  Module      : opo_package
//  Description : Shared datapath constants for the OPO lock-in signal chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package opo_package;
    localparam int WORD_WIDTH = 16;
endpackage
`default_nettype wire

// File: rtl/sample_ramp_interpolator_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ramp_interpolator_if
//  Description : Sparse sample input and per-clock interpolated output bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_ramp_interpolator_if;
    import opo_package::*;

    logic                         interp_enable;
    logic signed [WORD_WIDTH-1:0] sample_in;
    logic                         sample_in_valid;
    logic signed [WORD_WIDTH-1:0] sample_out;
    logic                         sample_out_valid;
    logic                         settled;

    modport master (
        output interp_enable, sample_in, sample_in_valid,
        input  sample_out, sample_out_valid, settled
    );

    modport slave (
        input  interp_enable, sample_in, sample_in_valid,
        output sample_out, sample_out_valid, settled
    );
endinterface
`default_nettype wire

// File: rtl/sample_ramp_interpolator.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ramp_interpolator
//  Description : Turns sparse filter samples into a per-clock linear ramp or hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_ramp_interpolator
    import opo_package::*;
#(
    parameter int RAMP_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    sample_ramp_interpolator_if.slave  bus
);

    localparam int C_WW = WORD_WIDTH;
    localparam int C_AW = WORD_WIDTH + RAMP_SHIFT + 1;
    localparam int C_CW = RAMP_SHIFT + 1;
    localparam logic [C_CW-1:0] C_LAST     = C_CW'(1) << RAMP_SHIFT;
    localparam bit              C_CAN_RAMP = (RAMP_SHIFT > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    state_t                  state_q;
    logic signed [C_AW-1:0]  acc_q;
    logic signed [C_WW:0]    delta_q;
    logic        [C_CW-1:0]  cnt_q;
    logic signed [C_WW-1:0]  target_q;
    logic                    valid_q;
    logic                    settled_q;

    logic signed [C_WW-1:0]  w_cur;
    logic signed [C_WW:0]    w_delta;
    logic signed [C_AW-1:0]  w_in_scaled;
    logic signed [C_AW-1:0]  w_restart_acc;
    logic signed [C_AW-1:0]  w_step_acc;
    logic signed [C_AW-1:0]  w_tgt_scaled;
    logic        [C_CW-1:0]  cnt_d;
    logic                    w_start_ramp;

    // The displayed value is the floor of the fixed-point accumulator.
    assign w_cur         = C_WW'(acc_q >>> RAMP_SHIFT);
    assign w_delta       = (C_WW+1)'(bus.sample_in) - (C_WW+1)'(w_cur);
    assign w_in_scaled   = C_AW'(bus.sample_in) <<< RAMP_SHIFT;
    assign w_restart_acc = (C_AW'(w_cur) <<< RAMP_SHIFT) + C_AW'(w_delta);
    assign w_step_acc    = acc_q + C_AW'(delta_q);
    assign w_tgt_scaled  = C_AW'(target_q) <<< RAMP_SHIFT;
    assign cnt_d         = cnt_q + C_CW'(1);
    assign w_start_ramp  = bus.interp_enable && C_CAN_RAMP && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            delta_q   <= '0;
            cnt_q     <= '0;
            target_q  <= '0;
            valid_q   <= 1'b0;
            settled_q <= 1'b0;
        end else if (bus.sample_in_valid) begin
            target_q <= bus.sample_in;
            valid_q  <= 1'b1;
            if (w_start_ramp) begin
                acc_q     <= w_restart_acc;
                delta_q   <= w_delta;
                cnt_q     <= C_CW'(1);
                state_q   <= S_RAMP;
                settled_q <= 1'b0;
            end else begin
                acc_q     <= w_in_scaled;
                state_q   <= S_HOLD;
                settled_q <= 1'b1;
            end
        end else if (state_q == S_RAMP) begin
            cnt_q <= cnt_d;
            // Final step loads the target directly so the endpoint is exact by construction.
            if (cnt_d == C_LAST) begin
                acc_q     <= w_tgt_scaled;
                state_q   <= S_HOLD;
                settled_q <= 1'b1;
            end else begin
                acc_q <= w_step_acc;
            end
        end
    end

    assign bus.sample_out       = w_cur;
    assign bus.sample_out_valid = valid_q;
    assign bus.settled          = settled_q;

endmodule
`default_nettype wire
